// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream of the FIFO stream reader.
// The master side is the reader; the slave side is the FIFO and the downstream sink.
interface fifo_stream_reader_if #(
  parameter int DW = 8
);
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_ren;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_ren, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_ren, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a one-cycle-latency synchronous FIFO into a valid/ready stream through a
// 3-entry skid buffer and frames the words into packets of PKT_LEN beats.
module fifo_stream_reader #(
  parameter int DW      = 8,
  parameter int PKT_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic                 busy,
  fifo_stream_reader_if.master bus
);

  localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);

  logic [DW-1:0] r_mem [3];
  logic [1:0]    r_head;
  logic [1:0]    r_tail;
  logic [1:0]    r_occ;
  logic          r_inflight;
  logic          r_run;
  logic [7:0]    r_beat;

  logic          w_valid;
  logic          w_pop;
  logic          w_last;
  logic          w_ren;
  logic [2:0]    w_fill;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads are budgeted against buffered plus in-flight words, so a capture always
  // finds a free slot and m_ready never reaches fifo_ren.
  always_comb begin
    w_fill  = {1'b0, r_occ} + {2'b00, r_inflight};
    w_valid = (r_occ != 2'd0);
    w_pop   = w_valid && bus.m_ready;
    w_last  = w_valid && (r_beat == LAST_BEAT);
    w_ren   = r_run && en && !bus.fifo_empty && (w_fill < 3'd3);
  end

  assign bus.fifo_ren = w_ren;
  assign bus.m_valid  = w_valid;
  assign bus.m_data   = w_valid ? r_mem[r_head] : '0;
  assign bus.m_last   = w_last;
  assign busy         = w_valid || r_inflight;

  // r_run keeps fifo_ren low while reset is asserted and for the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_inflight <= 1'b0;
      r_occ      <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_beat     <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_ren;

      if (r_inflight) begin
        r_mem[r_tail] <= bus.fifo_data;
        r_tail        <= ptr_inc(r_tail);
      end

      if (w_pop) begin
        r_head <= ptr_inc(r_head);
        r_beat <= w_last ? '0 : r_beat + 8'd1;
      end

      if (r_inflight && !w_pop) begin
        r_occ <= r_occ + 2'd1;
      end else if (!r_inflight && w_pop) begin
        r_occ <= r_occ - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: PKT_LEN=4 and PKT_LEN=1 instances, each fed
// by a behavioural one-cycle-latency FIFO.
module tb_fifo_stream_reader;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n   = 1'b1;
  logic en      = 1'b0;
  logic m_ready = 1'b0;
  logic flush   = 1'b1;
  logic busy4, busy1;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  fifo_stream_reader_if #(.DW(DW)) bus4 ();
  fifo_stream_reader_if #(.DW(DW)) bus1 ();

  fifo_stream_reader #(.DW(DW), .PKT_LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .busy(busy4), .bus(bus4.master)
  );
  fifo_stream_reader #(.DW(DW), .PKT_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .busy(busy1), .bus(bus1.master)
  );

  // Behavioural FIFOs: data_out registered on an accepted read.
  logic [DW-1:0] f4_mem [64];
  logic [DW-1:0] f1_mem [64];
  logic [DW-1:0] f4_q = '0;
  logic [DW-1:0] f1_q = '0;
  int f4_wr = 0, f4_rd = 0, f1_wr = 0, f1_rd = 0;
  int ren4_cnt = 0;

  assign bus4.fifo_empty = (f4_rd == f4_wr);
  assign bus4.fifo_data  = f4_q;
  assign bus4.m_ready    = m_ready;
  assign bus1.fifo_empty = (f1_rd == f1_wr);
  assign bus1.fifo_data  = f1_q;
  assign bus1.m_ready    = m_ready;

  always @(posedge clk) begin
    if (flush) begin
      f4_rd <= f4_wr;
      f1_rd <= f1_wr;
    end else begin
      if (bus4.fifo_ren) begin
        f4_q     <= f4_mem[f4_rd];
        f4_rd    <= f4_rd + 1;
        ren4_cnt <= ren4_cnt + 1;
      end
      if (bus1.fifo_ren) begin
        f1_q  <= f1_mem[f1_rd];
        f1_rd <= f1_rd + 1;
      end
    end
  end

  always @(negedge clk) begin
    if ((bus4.fifo_ren && bus4.fifo_empty) || (bus1.fifo_ren && bus1.fifo_empty))
      viol <= viol + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running want finished");
    $fatal(1);
  end

  task automatic push4(input logic [DW-1:0] d);
    f4_mem[f4_wr] = d;
    f4_wr++;
  endtask

  task automatic push1(input logic [DW-1:0] d);
    f1_mem[f1_wr] = d;
    f1_wr++;
  endtask

  task automatic do_reset();
    en = 1'b0; m_ready = 1'b0; flush = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    obs = {bus4.fifo_ren, bus4.m_valid, bus4.m_last, busy4, bus4.m_data};
    checks++;
    if (obs !== 12'h000) begin
      errors++; $display("FAIL reset4: got %h want 000", obs);
    end
    obs = {bus1.fifo_ren, bus1.m_valid, bus1.m_last, busy1, bus1.m_data};
    checks++;
    if (obs !== 12'h000) begin
      errors++; $display("FAIL reset1: got %h want 000", obs);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    // {fifo_ren, m_valid, m_last, busy, m_data} per cycle from en rising
    logic [11:0] exp [8] = '{12'h800, 12'h900, 12'hD11, 12'hD22, 12'hD33,
                             12'h744, 12'h555, 12'h000};
    logic [11:0] obs;
    do_reset();
    push4(8'h11); push4(8'h22); push4(8'h33); push4(8'h44); push4(8'h55);
    m_ready = 1'b1; en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      obs = {bus4.fifo_ren, bus4.m_valid, bus4.m_last, busy4, bus4.m_data};
      checks++;
      if (obs !== exp[c]) begin
        errors++; $display("FAIL b2b_c%0d: got %h want %h", c, obs, exp[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int base, got;
    do_reset();
    for (int i = 0; i < 5; i++) push4(words[i]);
    base = ren4_cnt;
    m_ready = 1'b0; en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c >= 2) begin
        checks++;
        if (bus4.m_valid !== 1'b1 || bus4.m_data !== 8'h11) begin
          errors++;
          $display("FAIL stall_hold_c%0d: got v=%b d=%h want v=1 d=11", c, bus4.m_valid, bus4.m_data);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ren4_cnt - base !== 3) begin
      errors++; $display("FAIL stall_reads: got %0d want 3", ren4_cnt - base);
    end
    m_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      #1;
      if (bus4.m_valid) begin
        checks++;
        if (bus4.m_data !== words[got] || bus4.m_last !== (got == 3)) begin
          errors++;
          $display("FAIL stall_word%0d: got d=%h l=%b want d=%h l=%b", got, bus4.m_data,
                   bus4.m_last, words[got], (got == 3));
        end
        got++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (got !== 5) begin
      errors++; $display("FAIL stall_count: got %0d want 5", got);
    end
    checks++;
    if (busy4 !== 1'b0 || bus4.m_valid !== 1'b0) begin
      errors++; $display("FAIL stall_idle: got busy=%b v=%b want 0 0", busy4, bus4.m_valid);
    end
  endtask

  task automatic test_alt_ready();
    int base, got;
    do_reset();
    for (int i = 1; i <= 8; i++) push4(8'(i));
    base = ren4_cnt;
    m_ready = 1'b1; en = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      #1;
      if (bus4.m_valid && m_ready) begin
        checks++;
        if (bus4.m_data !== 8'(got + 1) || bus4.m_last !== ((got % 4) == 3)) begin
          errors++;
          $display("FAIL alt_word%0d: got d=%h l=%b want d=%h l=%b", got, bus4.m_data,
                   bus4.m_last, 8'(got + 1), ((got % 4) == 3));
        end
        got++;
      end
      @(posedge clk); #1;
      m_ready = ~m_ready;
    end
    checks++;
    if (got !== 8) begin
      errors++; $display("FAIL alt_count: got %0d want 8", got);
    end
    checks++;
    if (ren4_cnt - base !== 8) begin
      errors++; $display("FAIL alt_reads: got %0d want 8", ren4_cnt - base);
    end
  endtask

  task automatic test_en_pause();
    logic [DW-1:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int got, low;
    bit dropped;
    do_reset();
    for (int i = 0; i < 5; i++) push4(words[i]);
    m_ready = 1'b1; en = 1'b1;
    got = 0; low = 0; dropped = 1'b0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      #1;
      if (!en) begin
        checks++;
        if (bus4.fifo_ren !== 1'b0) begin
          errors++; $display("FAIL pause_ren_c%0d: got %b want 0", c, bus4.fifo_ren);
        end
      end
      if (bus4.m_valid) begin
        checks++;
        if (bus4.m_data !== words[got] || bus4.m_last !== (got == 3)) begin
          errors++;
          $display("FAIL pause_word%0d: got d=%h l=%b want d=%h l=%b", got, bus4.m_data,
                   bus4.m_last, words[got], (got == 3));
        end
        got++;
      end
      if (got == 2 && !dropped) begin
        en = 1'b0; dropped = 1'b1;
      end else if (dropped && !en && low < 5) begin
        low++;
        if (low == 5) en = 1'b1;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (got !== 5) begin
      errors++; $display("FAIL pause_count: got %0d want 5", got);
    end
  endtask

  task automatic test_empty_toggle();
    do_reset();
    m_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push4(8'(8'hC0 + i));
      #1;
      checks++;
      if (bus4.fifo_ren !== 1'b1) begin
        errors++; $display("FAIL empty_read%0d: got ren=%b want 1", i, bus4.fifo_ren);
      end
      @(posedge clk); #1;
      checks++;
      if (bus4.fifo_ren !== 1'b0 || bus4.m_valid !== 1'b0) begin
        errors++;
        $display("FAIL empty_gap%0d: got ren=%b v=%b want 0 0", i, bus4.fifo_ren, bus4.m_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (bus4.m_valid !== 1'b1 || bus4.m_data !== 8'(8'hC0 + i) || bus4.m_last !== (i == 3)) begin
        errors++;
        $display("FAIL empty_word%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", i, bus4.m_valid,
                 bus4.m_data, bus4.m_last, 8'(8'hC0 + i), (i == 3));
      end
      @(posedge clk); #1;
      checks++;
      if (bus4.m_valid !== 1'b0 || busy4 !== 1'b0) begin
        errors++; $display("FAIL empty_drain%0d: got v=%b busy=%b want 0 0", i, bus4.m_valid, busy4);
      end
    end
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL ren_when_empty: got %0d want 0", viol);
    end
  endtask

  task automatic test_reset_midop();
    int g4, g1;
    do_reset();
    for (int i = 0; i < 5; i++) push4(8'(8'h11 * (i + 1)));
    push1(8'h61); push1(8'h62); push1(8'h63);
    m_ready = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy4 !== 1'b1 || bus4.m_valid !== 1'b1 || bus4.m_data !== 8'h11) begin
      errors++;
      $display("FAIL midop_pre: got busy=%b v=%b d=%h want 1 1 11", busy4, bus4.m_valid, bus4.m_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus4.m_valid, busy4, bus4.fifo_ren, bus1.m_valid, busy1, bus1.fifo_ren} !== 6'b0) begin
      errors++;
      $display("FAIL midop_async: got %b want 000000",
               {bus4.m_valid, busy4, bus4.fifo_ren, bus1.m_valid, busy1, bus1.fifo_ren});
    end
    en = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b0; rst_n = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus4.m_valid !== 1'b0 || bus1.m_valid !== 1'b0) begin
        errors++;
        $display("FAIL midop_stale_c%0d: got v4=%b v1=%b want 0 0", c, bus4.m_valid, bus1.m_valid);
      end
    end
    for (int i = 0; i < 4; i++) push4(8'(8'hA1 + i));
    push1(8'hB1); push1(8'hB2);
    en = 1'b1;
    g4 = 0; g1 = 0;
    for (int c = 0; c < 20 && (g4 < 4 || g1 < 2); c++) begin
      #1;
      if (bus4.m_valid) begin
        checks++;
        if (bus4.m_data !== 8'(8'hA1 + g4) || bus4.m_last !== (g4 == 3)) begin
          errors++;
          $display("FAIL midop_w4_%0d: got d=%h l=%b want d=%h l=%b", g4, bus4.m_data,
                   bus4.m_last, 8'(8'hA1 + g4), (g4 == 3));
        end
        g4++;
      end
      if (bus1.m_valid) begin
        checks++;
        if (bus1.m_data !== 8'(8'hB1 + g1) || bus1.m_last !== 1'b1) begin
          errors++;
          $display("FAIL midop_w1_%0d: got d=%h l=%b want d=%h l=1", g1, bus1.m_data,
                   bus1.m_last, 8'(8'hB1 + g1));
        end
        g1++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (g4 !== 4 || g1 !== 2) begin
      errors++; $display("FAIL midop_count: got %0d/%0d want 4/2", g4, g1);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_alt_ready();
    test_en_pause();
    test_empty_toggle();
    test_reset_midop();
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL ren_when_empty_total: got %0d want 0", viol);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
